// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : shared constants for the iterative multiply/divide unit.
//   OP_MULT / OP_DIV   : operation select values on the op input
//   ST_IDLE .. ST_DONE : 2-bit state encoding of the control FSM
// Optional feature macro used by the unit: MULTDIV_DIV0_EXC_EN
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if : request/response bundle between the multicycle control
// FSM (master) and the multiply/divide unit (slave).
//   start  : one-cycle request, sampled only while the unit is idle
//   op     : 0 = MULT, 1 = DIV
//   a_in   : operand A (multiplicand / dividend)
//   b_in   : operand B (multiplier / divisor)
//   busy   : operation in flight
//   done   : one-cycle completion pulse
//   hi_out : HI register (product high / remainder)
//   lo_out : LO register (product low / quotient)
//   div0   : divide-by-zero flag (only active with MULTDIV_DIV0_EXC_EN)
// ----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div0;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, hi_out, lo_out, div0
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, hi_out, lo_out, div0
    );

endinterface

// File: rtl/mult_div_unit_md_datapath.sv
// ----------------------------------------------------------------------------
// md_datapath : accumulator and arithmetic for the 1-bit-per-clock
// shift-add multiplier and restoring divider.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture |a|, |b|, sign bits and op (start accepted)
//   step         : perform one multiply/divide iteration
//   fix          : apply operand signs and write HI/LO
//   op           : OP_MULT / OP_DIV, sampled with load
//   a_in, b_in   : signed operands, sampled with load
//   hi_out       : HI register
//   lo_out       : LO register
// ----------------------------------------------------------------------------
module md_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    step,
    input  logic                    fix,
    input  logic                    op,
    input  logic signed [WIDTH-1:0] a_in,
    input  logic signed [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0]        hi_out,
    output logic [WIDTH-1:0]        lo_out
);

    localparam int AW = 2 * WIDTH + 1;

    // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1),
    // which is still representable as an unsigned W-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? -u : u;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_step;
    logic [AW-1:0]      shifted;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               op_q;
    logic               sa;
    logic               sb;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign mag_a = magnitude(a_in);
    assign mag_b = magnitude(b_in);

    // MULT: acc = {carry, upper half, multiplier}; the multiplier bits are
    // consumed from bit 0 while the product grows in from the top.
    // DIV:  acc = {sign, remainder, quotient}; the dividend bits shift out of
    // the quotient half into the remainder while quotient bits shift in.
    always_comb begin
        sum      = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = {acc[AW-2:0], 1'b0};
        trial    = shifted[AW-1:WIDTH] - {1'b0, opnd};
        acc_step = acc;
        if (op_q == OP_MULT) begin
            acc_step = {1'b0, sum, acc[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_step = {trial, shifted[WIDTH-1:1], 1'b1};
        end else begin
            acc_step = {shifted[AW-1:WIDTH], shifted[WIDTH-1:1], 1'b0};
        end
    end

    // Remainder follows the dividend's sign; quotient and product follow sa^sb.
    assign prod_fix = neg_2w(acc[2*WIDTH-1:0], sa ^ sb);
    assign quot_fix = neg_w(acc[WIDTH-1:0], sa ^ sb);
    assign rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], sa);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            opnd   <= '0;
            op_q   <= OP_MULT;
            sa     <= 1'b0;
            sb     <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else if (load) begin
            op_q <= op;
            sa   <= a_in[WIDTH-1];
            sb   <= b_in[WIDTH-1];
            if (op == OP_MULT) begin
                acc  <= {{(WIDTH+1){1'b0}}, mag_b};
                opnd <= mag_a;
            end else begin
                acc  <= {{(WIDTH+1){1'b0}}, mag_a};
                opnd <= mag_b;
            end
        end else if (step) begin
            acc <= acc_step;
        end else if (fix) begin
            if (op_q == OP_MULT) begin
                {hi_out, lo_out} <= prod_fix;
            end else begin
                hi_out <= rem_fix;
                lo_out <= quot_fix;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit : iterative signed multiply/divide unit producing HI/LO.
// Shift-add multiply and restoring divide, one bit per clock; a completed
// operation takes WIDTH+2 cycles from the start edge to the done pulse.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset (aborts any operation)
//   bus     : slave side of mult_div_unit_if (start/op/a_in/b_in in,
//             busy/done/hi_out/lo_out/div0 out)
// Optional feature macro: MULTDIV_DIV0_EXC_EN
//   defined   : DIV by zero completes immediately with div0=1, HI/LO kept
//   undefined : div0 tied to 0, DIV by zero runs the normal sequence
// ----------------------------------------------------------------------------
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_div_unit_if.slave  bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             take_div0;
    logic             load;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

`ifdef MULTDIV_DIV0_EXC_EN
    logic div0_q;

    assign take_div0 = (bus.op == OP_DIV) && (bus.b_in == '0);

    // Flag is raised on the IDLE->DONE shortcut and dropped when DONE ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div0_q <= 1'b0;
        end else if (accept) begin
            div0_q <= take_div0;
        end else if (state == ST_DONE) begin
            div0_q <= 1'b0;
        end
    end

    assign bus.div0 = div0_q;
`else
    assign take_div0 = 1'b0;
    assign bus.div0  = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && bus.start;
    assign load   = accept && !take_div0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt   <= '0;
                        state <= take_div0 ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_FIX:  state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.hi_out = hi;
    assign bus.lo_out = lo;

    md_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (state == ST_RUN),
        .fix     (state == ST_FIX),
        .op      (bus.op),
        .a_in    (bus.a_in),
        .b_in    (bus.b_in),
        .hi_out  (hi),
        .lo_out  (lo)
    );

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit : self-checking bench for mult_div_unit (WIDTH=32).
// Expected results come from signed 64-bit arithmetic in a reference task.
// Build with or without MULTDIV_DIV0_EXC_EN to match the DUT build.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    // Reference copy of HI/LO as the architecture should hold them.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: signed arithmetic on 64-bit integers.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic d0, output int cyc);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        d0  = 1'b0;
        cyc = 34;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
`ifdef MULTDIV_DIV0_EXC_EN
            hi  = m_hi;
            lo  = m_lo;
            d0  = 1'b1;
            cyc = 1;
`else
            hi = a;
            lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
        m_hi = hi;
        m_lo = lo;
    endtask

    // Issue one operation and observe it. cyc is the cycle index (1 = cycle
    // right after the start edge) in which done is seen, -1 on timeout.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int repulse_at,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic d0, output int cyc, output logic busy_ok,
                          output logic after_ok,
                          output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        cyc      = -1;
        busy_ok  = 1'b1;
        after_ok = 1'b0;
        hi       = '0;
        lo       = '0;
        d0       = 1'b0;
        mid_hi   = bus.hi_out;
        mid_lo   = bus.lo_out;
        for (int k = 1; k <= 100; k++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (k == 20) begin
                mid_hi = bus.hi_out;
                mid_lo = bus.lo_out;
            end
            if (bus.done === 1'b1) begin
                cyc = k;
                hi  = bus.hi_out;
                lo  = bus.lo_out;
                d0  = bus.div0;
                break;
            end
            if (k == repulse_at) begin
                bus.start = 1'b1;
                bus.op    = 1'b0;
                bus.a_in  = 32'd3;
                bus.b_in  = 32'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        if (cyc > 0) begin
            @(posedge clk);
            #1;
            after_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        m_hi      = '0;
        m_lo      = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done/div0 got %b required 000", {bus.busy, bus.done, bus.div0});
        end
        tests++;
        if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
            fails++;
            $display("FAIL reset_hilo: got %h_%h required 0", bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mult_basic();
        logic [31:0] hi, lo, mh, ml;
        logic        d0, bok, aok;
        int          cyc;
        run_op(1'b0, 32'd7, -32'sd3, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;
        tests++;
        if (cyc !== 34) begin
            fails++;
            $display("FAIL mult_latency: done in cycle %0d required 34", cyc);
        end
        tests++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            fails++;
            $display("FAIL mult_7x-3: got %h_%h required ffffffff_ffffffeb", hi, lo);
        end
        tests++;
        if (bok !== 1'b1 || aok !== 1'b1) begin
            fails++;
            $display("FAIL mult_busy: busy_in_run %b idle_after %b required 1 1", bok, aok);
        end
        tests++;
        if ({mh, ml} !== 64'd0) begin
            fails++;
            $display("FAIL mult_hold: mid-run HI/LO %h_%h required 0", mh, ml);
        end
    endtask

    task automatic test_mult_corner();
        logic [31:0] hi, lo, mh, ml;
        logic        d0, bok, aok;
        int          cyc;
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
        tests++;
        if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
            fails++;
            $display("FAIL mult_minxmin: got %h_%h required 40000000_00000000", hi, lo);
        end
        tests++;
        if ({mh, ml} !== {m_hi, m_lo}) begin
            fails++;
            $display("FAIL mult_hold2: mid-run HI/LO %h_%h required %h_%h", mh, ml, m_hi, m_lo);
        end
        m_hi = 32'h4000_0000;
        m_lo = 32'h0;
    endtask

    task automatic test_div_basic();
        logic [31:0] hi, lo, mh, ml;
        logic        d0, bok, aok;
        int          cyc;
        run_op(1'b1, -32'sd7, 32'd2, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
        tests++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || cyc !== 34) begin
            fails++;
            $display("FAIL div_-7/2: got %h_%h cyc %0d required ffffffff_fffffffd cyc 34", hi, lo, cyc);
        end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
        tests++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000 || d0 !== 1'b0) begin
            fails++;
            $display("FAIL div_overflow: got %h_%h div0 %b required 00000000_80000000 div0 0", hi, lo, d0);
        end
        m_hi = 32'h0;
        m_lo = 32'h8000_0000;
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo, mh, ml;
        logic        d0, bok, aok;
        int          cyc;
        int          extra;
        run_op(1'b1, 32'd100, -32'sd7, 10, hi, lo, d0, cyc, bok, aok, mh, ml);
        tests++;
        if ({hi, lo} !== 64'h0000_0002_FFFF_FFF2 || cyc !== 34) begin
            fails++;
            $display("FAIL restart_ignored: got %h_%h cyc %0d required 00000002_fffffff2 cyc 34", hi, lo, cyc);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL restart_single_done: extra done pulses %0d required 0", extra);
        end
        m_hi = 32'h2;
        m_lo = 32'hFFFF_FFF2;
    endtask

    task automatic test_reset_abort();
        logic [31:0] hi, lo, mh, ml, ehi, elo;
        logic        d0, ed0, bok, aok;
        int          cyc, ecyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'h1234_5678;
        bus.b_in  = 32'h0000_0100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++;
            $display("FAIL abort_ctrl: busy/done got %b required 00", {bus.busy, bus.done});
        end
        tests++;
        if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
            fails++;
            $display("FAIL abort_hilo: got %h_%h required 0", bus.hi_out, bus.lo_out);
        end
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        model(1'b0, 32'hFFFF_FF00, 32'd25, ehi, elo, ed0, ecyc);
        run_op(1'b0, 32'hFFFF_FF00, 32'd25, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
        tests++;
        if ({hi, lo} !== {ehi, elo} || cyc !== ecyc) begin
            fails++;
            $display("FAIL abort_recover: got %h_%h cyc %0d required %h_%h cyc %0d", hi, lo, cyc, ehi, elo, ecyc);
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] hi, lo, mh, ml, ehi, elo;
        logic        d0, ed0, bok, aok;
        int          cyc, ecyc;
        logic [31:0] avals [2];
        avals[0] = 32'd5;
        avals[1] = 32'hFFFF_FFF7;
        for (int i = 0; i < 2; i++) begin
            model(1'b1, avals[i], 32'd0, ehi, elo, ed0, ecyc);
            run_op(1'b1, avals[i], 32'd0, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
            tests++;
            if ({hi, lo} !== {ehi, elo}) begin
                fails++;
                $display("FAIL div0_result a=%h: got %h_%h required %h_%h", avals[i], hi, lo, ehi, elo);
            end
            tests++;
            if (d0 !== ed0 || cyc !== ecyc || aok !== 1'b1) begin
                fails++;
                $display("FAIL div0_flag a=%h: div0 %b cyc %0d idle_after %b required %b %0d 1",
                         avals[i], d0, cyc, aok, ed0, ecyc);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, mh, ml, ehi, elo, a, b;
        logic        d0, ed0, bok, aok, op;
        int          cyc, ecyc;
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 28);
            model(op, a, b, ehi, elo, ed0, ecyc);
            run_op(op, a, b, 0, hi, lo, d0, cyc, bok, aok, mh, ml);
            tests++;
            if ({hi, lo} !== {ehi, elo} || d0 !== ed0 || cyc !== ecyc || bok !== 1'b1) begin
                fails++;
                $display("FAIL random op=%b a=%h b=%h: got %h_%h div0 %b cyc %0d busy %b required %h_%h div0 %b cyc %0d",
                         op, a, b, hi, lo, d0, cyc, bok, ehi, elo, ed0, ecyc);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mult_basic();
        test_mult_corner();
        test_div_basic();
        test_back_to_back();
        test_reset_abort();
        test_div_by_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
